// File: rtl/debounce_pkg.sv
// Shared constants and sizing helper for the multi-channel switch debouncer.
package debounce_pkg;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_SYNC_STAGES   = 2;

    // Bits needed to hold 0..max_val; never returns 0 so a count of 1 still gets a real flop.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: synchroniser, stability filter, registered edge pulses
// and an optional long-press pulse.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_hold
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    logic w_s;
    logic w_diff;
    logic w_flip;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_diff = (w_s != r_level);
    assign w_flip = w_diff && (r_cnt == CNT_LAST);

    // Any agreement between the synchronised input and the level restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_rise <= w_flip && w_s;
            r_fall <= w_flip && !w_s;
            if (!w_diff || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_flip) begin
                r_level <= w_s;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

    generate
        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int HCNT_W = cnt_width(HOLD_CYCLES);
            localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HOLD_CYCLES);
            localparam logic [HCNT_W-1:0] HCNT_PRE = HCNT_W'(HOLD_CYCLES - 1);
            localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1);

            logic [HCNT_W-1:0] r_hcnt;
            logic              r_hold;
            logic              w_falling;

            assign w_falling = w_flip && !w_s;

            // Saturating at HCNT_MAX gives at most one hold pulse per press.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_hcnt <= '0;
                    r_hold <= 1'b0;
                end else begin
                    r_hold <= r_level && !w_falling && (r_hcnt == HCNT_PRE);
                    if (!r_level || w_falling) begin
                        r_hcnt <= '0;
                    end else if (r_hcnt != HCNT_MAX) begin
                        r_hcnt <= r_hcnt + HCNT_ONE;
                    end
                end
            end

            assign o_hold = r_hold;
        end else begin : g_no_hold
            assign o_hold = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/debounce_multi.sv
// Bank of independent switch debouncers, one debounce_chan per raw input.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] raw_sig_i,
    output logic [NUM_CH-1:0] debounce_sig_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] hold_o
);

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_chan
            debounce_chan #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .HOLD_CYCLES   (HOLD_CYCLES),
                .SYNC_STAGES   (SYNC_STAGES)
            ) u_chan (
                .i_clk   (clk_i),
                .i_rst_n (rst_ni),
                .i_raw   (raw_sig_i[g]),
                .o_level (debounce_sig_o[g]),
                .o_rise  (rise_o[g]),
                .o_fall  (fall_o[g]),
                .o_hold  (hold_o[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi (2 channels, default timing) with a
// window-based reference model checked every cycle.
module tb_debounce_multi;

    localparam int NCH  = 2;
    localparam int ST   = 4;
    localparam int HOLD = 16;
    localparam int SYNC = 2;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] deb;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] hold;

    int n_asr  = 0;
    int n_fail = 0;

    debounce_multi #(
        .NUM_CH        (NCH),
        .STABLE_CYCLES (ST),
        .HOLD_CYCLES   (HOLD),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .raw_sig_i      (raw),
        .debounce_sig_o (deb),
        .rise_o         (rise),
        .fall_o         (fall),
        .hold_o         (hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_asr++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the level flips once the last ST synchronised samples
    // all disagree with it; hold fires when a press reaches age HOLD.
    logic [NCH-1:0] m_rawq [SYNC] = '{default: '0};
    logic [NCH-1:0] m_swin [ST]   = '{default: '0};
    logic [NCH-1:0] m_lvl  = '0;
    logic [NCH-1:0] m_rise = '0;
    logic [NCH-1:0] m_fall = '0;
    logic [NCH-1:0] m_hold = '0;
    int             m_age [NCH]   = '{default: 0};

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int j = 0; j < SYNC; j++) m_rawq[j] = '0;
                for (int j = 0; j < ST; j++) m_swin[j] = '0;
                m_lvl  = '0;
                m_rise = '0;
                m_fall = '0;
                m_hold = '0;
                for (int c = 0; c < NCH; c++) m_age[c] = 0;
            end else begin
                for (int j = ST - 1; j > 0; j--) m_swin[j] = m_swin[j-1];
                m_swin[0] = m_rawq[SYNC-1];
                for (int j = SYNC - 1; j > 0; j--) m_rawq[j] = m_rawq[j-1];
                m_rawq[0] = raw;
                m_rise = '0;
                m_fall = '0;
                m_hold = '0;
                for (int c = 0; c < NCH; c++) begin
                    automatic bit all_diff = 1'b1;
                    for (int k = 0; k < ST; k++)
                        if (m_swin[k][c] == m_lvl[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        if (m_lvl[c]) m_fall[c] = 1'b1;
                        else          m_rise[c] = 1'b1;
                        m_lvl[c] = ~m_lvl[c];
                        m_age[c] = 0;
                    end else if (m_lvl[c]) begin
                        m_age[c]++;
                        if (m_age[c] == HOLD) m_hold[c] = 1'b1;
                    end
                end
            end
        end
    end

    int cnt_rise [NCH] = '{default: 0};
    int cnt_fall [NCH] = '{default: 0};
    int cnt_hold [NCH] = '{default: 0};
    int fall_cyc [NCH] = '{default: 0};
    int cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            chk("model_level", int'(deb),  int'(m_lvl));
            chk("model_rise",  int'(rise), int'(m_rise));
            chk("model_fall",  int'(fall), int'(m_fall));
            chk("model_hold",  int'(hold), int'(m_hold));
            if (rise == fall && rise != '0) chk("rise_fall_overlap", 1, 0);
            if (rst_n) begin
                for (int c = 0; c < NCH; c++) begin
                    if (rise[c]) cnt_rise[c]++;
                    if (fall[c]) begin
                        cnt_fall[c]++;
                        fall_cyc[c] = cyc;
                    end
                    if (hold[c]) cnt_hold[c]++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        raw   = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_level", int'(deb),  0);
        chk("reset_rise",  int'(rise), 0);
        chk("reset_fall",  int'(fall), 0);
        chk("reset_hold",  int'(hold), 0);
        @(negedge clk);
        rst_n = 1'b1;
        raw   = 2'b00;
        repeat (4) @(negedge clk);

        // Clean press that doubles as a long press (raw[0] high 30 cycles)
        @(negedge clk);
        raw = 2'b01;
        repeat (5) @(posedge clk);
        #1 chk("press_before_k5", int'(deb), 0);
        @(posedge clk);
        #1 chk("press_level_k5", int'(deb), 1);
        chk("press_rise_k5", int'(rise), 1);
        @(posedge clk);
        #1 chk("press_rise_one_cycle", int'(rise), 0);
        repeat (14) @(posedge clk);
        #1 chk("hold_before", int'(hold), 0);
        @(posedge clk);
        #1 chk("hold_at_16", int'(hold), 1);
        @(posedge clk);
        #1 chk("hold_one_cycle", int'(hold), 0);
        repeat (8) @(negedge clk);
        raw = 2'b00;
        repeat (10) @(negedge clk);
        #1;
        chk("long_rise_cnt", cnt_rise[0], 1);
        chk("long_fall_cnt", cnt_fall[0], 1);
        chk("long_hold_cnt", cnt_hold[0], 1);
        chk("long_ch1_quiet", cnt_rise[1], 0);
        chk("long_level_end", int'(deb), 0);

        // Bounce: toggle every cycle, never stable long enough
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            raw[0] = ~raw[0];
        end
        raw = 2'b00;
        repeat (8) @(negedge clk);
        #1;
        chk("bounce_rise_cnt", cnt_rise[0], 1);
        chk("bounce_fall_cnt", cnt_fall[0], 1);

        // Threshold: 3 cycles rejected, 4 cycles accepted
        @(negedge clk);
        raw[1] = 1'b1;
        repeat (3) @(negedge clk);
        raw[1] = 1'b0;
        repeat (8) @(negedge clk);
        #1 chk("thresh3_no_rise", cnt_rise[1], 0);
        @(negedge clk);
        raw[1] = 1'b1;
        repeat (4) @(negedge clk);
        raw[1] = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("thresh4_rise_cnt", cnt_rise[1], 1);
        chk("thresh4_fall_cnt", cnt_fall[1], 1);
        chk("thresh4_no_hold", cnt_hold[1], 0);

        // Concurrency: common press, staggered release
        @(negedge clk);
        raw = 2'b11;
        repeat (6) @(posedge clk);
        #1;
        chk("conc_rise_both", int'(rise), 3);
        chk("conc_level_both", int'(deb), 3);
        @(negedge clk);
        raw = 2'b10;
        repeat (2) @(negedge clk);
        raw = 2'b00;
        repeat (10) @(negedge clk);
        #1;
        chk("conc_fall_gap", fall_cyc[1] - fall_cyc[0], 2);
        chk("conc_fall_cnt0", cnt_fall[0], 2);

        // Asynchronous reset while both levels are high
        @(negedge clk);
        raw = 2'b11;
        repeat (10) @(posedge clk);
        #1 chk("pre_reset_level", int'(deb), 3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_level", int'(deb), 0);
        chk("async_reset_hold",  int'(hold), 0);
        @(negedge clk);
        raw   = 2'b00;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1 chk("post_reset_level", int'(deb), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
        $finish;
    end

endmodule
